// File: rtl/cmd_parse_regs_if.sv
// Signal bundle between the UART command parser, its receive / echo / response
// neighbours and the car control logic fed from the register bank.
interface cmd_parse_regs_if #(
    parameter int NUM_REGS = 4,
    parameter int ARG_CH   = 8
);
    localparam int DW = 4 * ARG_CH;

    logic [7:0]             rx_data;
    logic                   rx_data_rdy;
    logic                   char_fifo_full;
    logic                   send_char_val;
    logic [7:0]             send_char;
    logic                   send_resp_val;
    logic [1:0]             send_resp_type;
    logic [DW-1:0]          send_resp_data;
    logic                   send_resp_done;
    logic [NUM_REGS*DW-1:0] reg_bus;
    logic                   reg_wr_stb;
    logic [3:0]             reg_wr_idx;

    modport slave (
        input  rx_data, rx_data_rdy, char_fifo_full, send_resp_done,
        output send_char_val, send_char, send_resp_val, send_resp_type,
        output send_resp_data, reg_bus, reg_wr_stb, reg_wr_idx
    );

    modport master (
        output rx_data, rx_data_rdy, char_fifo_full, send_resp_done,
        input  send_char_val, send_char, send_resp_val, send_resp_type,
        input  send_resp_data, reg_bus, reg_wr_stb, reg_wr_idx
    );
endinterface

// File: rtl/cmd_parse_regs.sv
// ASCII command parser ("*W<i><hex>", "*R<i>", "*C") loading a bank of hex
// registers, with echo, inter-character timeout and '*' resync.
module cmd_parse_regs #(
    parameter int NUM_REGS = 4,
    parameter int ARG_CH   = 8,
    parameter int TO_CYC   = 1000000
) (
    input  logic            clk_rx,
    input  logic            rst_clk_rx_n,
    cmd_parse_regs_if.slave bus
);
    localparam int DW = 4 * ARG_CH;
    localparam int CW = (ARG_CH > 1) ? $clog2(ARG_CH) : 1;
    localparam int TW = $clog2(TO_CYC);

    localparam logic [6:0] CH_STAR = 7'h2A;
    localparam logic [6:0] CH_W    = 7'h57;
    localparam logic [6:0] CH_R    = 7'h52;
    localparam logic [6:0] CH_C    = 7'h43;

    typedef enum logic [2:0] {IDLE, CMD_WAIT, GET_IDX, GET_ARG, SEND_RESP} state_t;
    typedef enum logic [1:0] {RESP_OK = 2'b00, RESP_ERR = 2'b01, RESP_DATA = 2'b10} resp_t;

    state_t          state_q, state_d;
    logic            rdy_d1_q, rdy_d1_d;
    logic            echo_val_q, echo_val_d;
    logic [7:0]      echo_char_q, echo_char_d;
    logic            is_wr_q, is_wr_d;
    logic [3:0]      idx_q, idx_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [DW-1:0]   shift_q, shift_d;
    logic [DW-1:0]   regs_q [NUM_REGS];
    logic [DW-1:0]   regs_d [NUM_REGS];
    logic            resp_val_q, resp_val_d;
    resp_t           resp_type_q, resp_type_d;
    logic [DW-1:0]   resp_data_q, resp_data_d;
    logic            wr_stb_q, wr_stb_d;
    logic [3:0]      wr_idx_q, wr_idx_d;
    logic [TW-1:0]   to_cnt_q, to_cnt_d;

    logic            new_char, timeout, hex_ok, idx_ok, rsp;
    logic [6:0]      ch, ch_uc;
    logic [3:0]      hex_val;
    logic [DW-1:0]   rd_data, shift_next;
    resp_t           rsp_type;

    assign new_char = bus.rx_data_rdy & ~rdy_d1_q & ~bus.char_fifo_full;
    assign timeout  = (to_cnt_q == TW'(TO_CYC - 1));

    // Character classification: case-folded letter and hex digit value.
    always_comb begin
        ch      = bus.rx_data[6:0];
        ch_uc   = (ch >= 7'h61 && ch <= 7'h7A) ? ch - 7'h20 : ch;
        hex_ok  = 1'b0;
        hex_val = 4'h0;
        if (ch_uc >= 7'h30 && ch_uc <= 7'h39) begin
            hex_ok  = 1'b1;
            hex_val = 4'(ch_uc - 7'h30);
        end else if (ch_uc >= 7'h41 && ch_uc <= 7'h46) begin
            hex_ok  = 1'b1;
            hex_val = 4'(ch_uc - 7'h37);
        end
        idx_ok     = ({1'b0, hex_val} < 5'(NUM_REGS));
        shift_next = (shift_q << 4) | DW'(hex_val);
        rd_data    = '0;
        for (int i = 0; i < NUM_REGS; i++)
            if (hex_val == 4'(i)) rd_data = regs_q[i];
    end

    always_comb begin
        // NOTE: every variable gets its hold/default value first so no path infers a latch.
        state_d     = state_q;
        rdy_d1_d    = bus.rx_data_rdy;
        echo_val_d  = new_char;
        echo_char_d = new_char ? bus.rx_data : echo_char_q;
        is_wr_d     = is_wr_q;
        idx_d       = idx_q;
        cnt_d       = cnt_q;
        shift_d     = shift_q;
        regs_d      = regs_q;
        resp_val_d  = resp_val_q;
        resp_type_d = resp_type_q;
        resp_data_d = resp_data_q;
        wr_stb_d    = 1'b0;
        wr_idx_d    = wr_idx_q;
        rsp         = 1'b0;
        rsp_type    = RESP_ERR;

        case (state_q)
            IDLE: if (new_char && ch == CH_STAR) state_d = CMD_WAIT;
            CMD_WAIT: begin
                if (new_char) begin
                    if (ch_uc == CH_W || ch_uc == CH_R) begin
                        is_wr_d = (ch_uc == CH_W);
                        state_d = GET_IDX;
                    end else if (ch_uc == CH_C) begin
                        for (int i = 0; i < NUM_REGS; i++) regs_d[i] = '0;
                        wr_stb_d = 1'b1;
                        wr_idx_d = 4'h0;
                        rsp      = 1'b1;
                        rsp_type = RESP_OK;
                    end else if (ch != CH_STAR) begin
                        rsp = 1'b1;
                    end
                end else if (timeout) begin
                    rsp = 1'b1;
                end
            end
            GET_IDX: begin
                if (new_char) begin
                    if (ch == CH_STAR) begin
                        state_d = CMD_WAIT;
                    end else if (!hex_ok || !idx_ok) begin
                        rsp = 1'b1;
                    end else if (is_wr_q) begin
                        idx_d   = hex_val;
                        cnt_d   = CW'(ARG_CH - 1);
                        shift_d = '0;
                        state_d = GET_ARG;
                    end else begin
                        rsp         = 1'b1;
                        rsp_type    = RESP_DATA;
                        resp_data_d = rd_data;
                    end
                end else if (timeout) begin
                    rsp = 1'b1;
                end
            end
            GET_ARG: begin
                if (new_char) begin
                    if (ch == CH_STAR) begin
                        state_d = CMD_WAIT;
                    end else if (!hex_ok) begin
                        rsp = 1'b1;
                    end else if (cnt_q == '0) begin
                        for (int i = 0; i < NUM_REGS; i++)
                            if (idx_q == 4'(i)) regs_d[i] = shift_next;
                        wr_stb_d = 1'b1;
                        wr_idx_d = idx_q;
                        rsp      = 1'b1;
                        rsp_type = RESP_OK;
                    end else begin
                        cnt_d   = cnt_q - 1'b1;
                        shift_d = shift_next;
                    end
                end else if (timeout) begin
                    rsp = 1'b1;
                end
            end
            SEND_RESP: begin
                if (bus.send_resp_done) begin
                    resp_val_d = 1'b0;
                    state_d    = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        if (rsp) begin
            resp_val_d  = 1'b1;
            resp_type_d = rsp_type;
            state_d     = SEND_RESP;
        end

        // Idle-time counter only runs while a command is partially received.
        if (state_q inside {IDLE, SEND_RESP} || new_char || timeout) to_cnt_d = '0;
        else                                                         to_cnt_d = to_cnt_q + TW'(1);
    end

    always_ff @(posedge clk_rx or negedge rst_clk_rx_n) begin
        if (!rst_clk_rx_n) begin
            state_q     <= IDLE;
            rdy_d1_q    <= 1'b0;
            echo_val_q  <= 1'b0;
            echo_char_q <= 8'h00;
            is_wr_q     <= 1'b0;
            idx_q       <= 4'h0;
            cnt_q       <= '0;
            shift_q     <= '0;
            resp_val_q  <= 1'b0;
            resp_type_q <= RESP_ERR;
            resp_data_q <= '0;
            wr_stb_q    <= 1'b0;
            wr_idx_q    <= 4'h0;
            to_cnt_q    <= '0;
            // NOTE: the register bank is reset too; it drives car control directly and must never be X.
            for (int i = 0; i < NUM_REGS; i++) regs_q[i] <= '0;
        end else begin
            // NOTE: non-blocking assignments so every flop samples the pre-edge value of the others.
            state_q     <= state_d;
            rdy_d1_q    <= rdy_d1_d;
            echo_val_q  <= echo_val_d;
            echo_char_q <= echo_char_d;
            is_wr_q     <= is_wr_d;
            idx_q       <= idx_d;
            cnt_q       <= cnt_d;
            shift_q     <= shift_d;
            resp_val_q  <= resp_val_d;
            resp_type_q <= resp_type_d;
            resp_data_q <= resp_data_d;
            wr_stb_q    <= wr_stb_d;
            wr_idx_q    <= wr_idx_d;
            to_cnt_q    <= to_cnt_d;
            regs_q      <= regs_d;
        end
    end

    assign bus.send_char_val  = echo_val_q;
    assign bus.send_char      = echo_char_q;
    assign bus.send_resp_val  = resp_val_q;
    assign bus.send_resp_type = resp_type_q;
    assign bus.send_resp_data = resp_data_q;
    assign bus.reg_wr_stb     = wr_stb_q;
    assign bus.reg_wr_idx     = wr_idx_q;

    for (genvar g = 0; g < NUM_REGS; g++) begin : g_bus
        assign bus.reg_bus[g*DW +: DW] = regs_q[g];
    end
endmodule

// File: tb/tb_cmd_parse_regs.sv
// Scoreboard bench for cmd_parse_regs: string-level command model predicts
// echoes, register writes and responses; a monitor checks them as they appear.
module tb_cmd_parse_regs;
    localparam int NUM_REGS = 4;
    localparam int ARG_CH   = 8;
    localparam int TO_CYC   = 20;
    localparam int DW       = 4 * ARG_CH;
    localparam int BW       = NUM_REGS * DW;
    localparam logic [1:0] T_OK = 2'b00, T_ERR = 2'b01, T_DATA = 2'b10;

    typedef struct { logic [1:0] typ; logic [DW-1:0] data; int at_cyc; } exp_resp_t;
    typedef struct { logic [3:0] idx; logic [BW-1:0] bus; } exp_wr_t;

    logic clk_rx       = 1'b0;
    logic rst_clk_rx_n = 1'b0;
    int   cyc          = 0;
    int   n_checks     = 0;
    int   n_fail       = 0;
    int   n_echo       = 0;
    int   resp_hold    = 2;

    exp_resp_t     resp_q[$];
    exp_wr_t       wr_q[$];
    logic [7:0]    echo_q[$];
    byte           tx_q[$];

    logic [DW-1:0] m_regs [NUM_REGS];
    bit            m_active, m_busy;
    byte           m_buf[$];
    int            m_last_edge;

    always #5 clk_rx = ~clk_rx;
    always @(posedge clk_rx) cyc <= cyc + 1;

    cmd_parse_regs_if #(.NUM_REGS(NUM_REGS), .ARG_CH(ARG_CH)) bus ();

    cmd_parse_regs #(.NUM_REGS(NUM_REGS), .ARG_CH(ARG_CH), .TO_CYC(TO_CYC)) dut (
        .clk_rx       (clk_rx),
        .rst_clk_rx_n (rst_clk_rx_n),
        .bus          (bus)
    );

    task automatic check(input string name, input logic [BW-1:0] act, input logic [BW-1:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // ---------------- reference model ----------------
    function automatic logic [BW-1:0] model_bus();
        logic [BW-1:0] b;
        for (int i = 0; i < NUM_REGS; i++) b[i*DW +: DW] = m_regs[i];
        return b;
    endfunction

    function automatic int hexval(input byte u);
        if (u >= "0" && u <= "9") return int'(u) - int'("0");
        if (u >= "A" && u <= "F") return int'(u) - int'("A") + 10;
        return -1;
    endfunction

    task automatic respond(input logic [1:0] typ, input logic [DW-1:0] data, input int at);
        resp_q.push_back('{typ, data, at});
        m_active = 1'b0;
        m_busy   = 1'b1;
    endtask

    // Re-judges the whole buffered command text after every accepted character.
    task automatic model_eval(input int at);
        byte cmd;
        int  ix, d;
        logic [DW-1:0] v;
        cmd = m_buf[0];
        if (cmd == "C") begin
            for (int i = 0; i < NUM_REGS; i++) m_regs[i] = '0;
            wr_q.push_back('{4'h0, model_bus()});
            respond(T_OK, '0, at);
        end else if (cmd != "W" && cmd != "R") begin
            respond(T_ERR, '0, at);
        end else if (m_buf.size() >= 2) begin
            ix = hexval(m_buf[1]);
            if (ix < 0 || ix >= NUM_REGS) respond(T_ERR, '0, at);
            else if (cmd == "R")          respond(T_DATA, m_regs[ix], at);
            else if (m_buf.size() > 2) begin
                if (hexval(m_buf[m_buf.size()-1]) < 0) respond(T_ERR, '0, at);
                else if (m_buf.size() == 2 + ARG_CH) begin
                    v = '0;
                    for (int k = 2; k < m_buf.size(); k++) begin
                        d = hexval(m_buf[k]);
                        v = v * 16 + DW'(d);
                    end
                    m_regs[ix] = v;
                    wr_q.push_back('{4'(ix), model_bus()});
                    respond(T_OK, '0, at);
                end
            end
        end
    endtask

    task automatic model_char(input byte c, input int at);
        byte u;
        u = byte'(c & 8'h7F);
        if (m_busy) return;
        if (!m_active) begin
            if (u == "*") begin
                m_active = 1'b1;
                m_buf.delete();
                m_last_edge = at;
            end
            return;
        end
        m_last_edge = at;
        if (u == "*") begin
            m_buf.delete();
            return;
        end
        if (u >= "a" && u <= "z") u = u - 8'd32;
        m_buf.push_back(u);
        model_eval(at);
    endtask

    // ---------------- stimulus helpers ----------------
    task automatic send_ch(input byte c, input bit drop);
        @(negedge clk_rx);
        bus.char_fifo_full = drop;
        bus.rx_data        = c;
        bus.rx_data_rdy    = 1'b1;
        if (!drop) begin
            echo_q.push_back(c);
            model_char(c, cyc + 1);
        end
        repeat (3) @(negedge clk_rx);
        bus.rx_data_rdy    = 1'b0;
        bus.char_fifo_full = 1'b0;
        @(negedge clk_rx);
    endtask

    task automatic send_str(input string s);
        for (int i = 0; i < s.len(); i++) send_ch(s[i], 1'b0);
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while ((m_busy || resp_q.size() != 0) && n < 400) begin
            @(negedge clk_rx);
            n++;
        end
        if (m_busy || resp_q.size() != 0) begin
            check("resp_wait_bound", 1, 0);
            resp_q.delete();
            m_busy = 1'b0;
        end
        @(negedge clk_rx);
    endtask

    task automatic expect_timeout();
        respond(T_ERR, '0, m_last_edge + TO_CYC);
    endtask

    // ---------------- monitor ----------------
    initial begin
        bit in_resp, done_on;
        int hold;
        exp_resp_t er;
        exp_wr_t   ew;
        in_resp = 1'b0;
        done_on = 1'b0;
        hold    = 0;
        bus.send_resp_done = 1'b0;
        forever begin
            @(negedge clk_rx);
            if (rst_clk_rx_n) begin
                if (bus.send_char_val) begin
                    n_echo++;
                    if (echo_q.size() == 0) check("echo_unexpected", {8'h0, bus.send_char}, 9'h100);
                    else                    check("echo_char", bus.send_char, echo_q.pop_front());
                end
                if (bus.reg_wr_stb) begin
                    if (wr_q.size() == 0) check("wr_stb_unexpected", 1, 0);
                    else begin
                        ew = wr_q.pop_front();
                        check("reg_wr_idx", bus.reg_wr_idx, ew.idx);
                        check("reg_bus_at_wr", bus.reg_bus, ew.bus);
                    end
                end
                if (!in_resp && bus.send_resp_val) begin
                    in_resp = 1'b1;
                    hold    = resp_hold;
                    if (resp_q.size() == 0) check("resp_unexpected", 1, 0);
                    else begin
                        er = resp_q[0];
                        check("resp_type", bus.send_resp_type, er.typ);
                        if (er.typ == T_DATA) check("resp_data", bus.send_resp_data, er.data);
                        check("resp_cycle", cyc, er.at_cyc);
                    end
                end else if (in_resp) begin
                    if (done_on) begin
                        bus.send_resp_done = 1'b0;
                        done_on = 1'b0;
                        in_resp = 1'b0;
                        check("resp_val_drop", bus.send_resp_val, 0);
                        if (resp_q.size() != 0) void'(resp_q.pop_front());
                        m_busy = 1'b0;
                    end else begin
                        check("resp_val_held", bus.send_resp_val, 1);
                        hold--;
                        if (hold <= 0) begin
                            bus.send_resp_done = 1'b1;
                            done_on = 1'b1;
                        end
                    end
                end
            end
        end
    end

    task automatic check_reset_outputs(input string tag);
        check({tag, "_echo_val"}, bus.send_char_val, 0);
        check({tag, "_echo_char"}, bus.send_char, 0);
        check({tag, "_resp_val"}, bus.send_resp_val, 0);
        check({tag, "_resp_type"}, bus.send_resp_type, T_ERR);
        check({tag, "_resp_data"}, bus.send_resp_data, 0);
        check({tag, "_reg_bus"}, bus.reg_bus, 0);
        check({tag, "_wr_stb"}, bus.reg_wr_stb, 0);
        check({tag, "_wr_idx"}, bus.reg_wr_idx, 0);
    endtask

    // ---------------- main sequence ----------------
    initial begin
        string hexs;
        int    e0, kind;
        hexs = "0123456789abcdefABCDEF";
        bus.rx_data = 8'h00;
        bus.rx_data_rdy = 1'b0;
        bus.char_fifo_full = 1'b0;
        for (int i = 0; i < NUM_REGS; i++) m_regs[i] = '0;
        m_active = 1'b0;
        m_busy   = 1'b0;
        m_last_edge = 0;
        repeat (3) @(negedge clk_rx);
        check_reset_outputs("reset");
        rst_clk_rx_n = 1'b1;
        repeat (2) @(negedge clk_rx);

        e0 = n_echo;
        send_str("*W212345678");
        wait_idle();
        check("echo_count_w2", n_echo - e0, 11);
        check("reg2_value", bus.reg_bus[95:64], 32'h12345678);
        send_str("*r2");
        wait_idle();
        send_str("*W0CAFEF00D");
        wait_idle();
        send_str("*W5");
        wait_idle();
        check("bus_after_bad_idx", bus.reg_bus, model_bus());
        send_str("*W01234G");
        wait_idle();
        check("bus_after_bad_hex", bus.reg_bus, model_bus());

        send_str("*W0AB");
        expect_timeout();
        wait_idle();
        send_str("*R0");
        wait_idle();

        send_str("*W0FF*W1DEADBEEF");
        wait_idle();
        check("reg1_deadbeef", bus.reg_bus[63:32], 32'hDEADBEEF);
        check("reg0_kept", bus.reg_bus[31:0], 32'hCAFEF00D);

        send_str("*c");
        wait_idle();
        check("bus_cleared", bus.reg_bus, 0);

        resp_hold = 50;
        send_str("*R1");
        send_str("*W1");
        wait_idle();
        resp_hold = 2;
        check("bus_after_suspend", bus.reg_bus, model_bus());

        for (int it = 0; it < 40; it++) begin
            tx_q.delete();
            if ($urandom_range(0, 3) == 0) send_ch("x", 1'(($urandom_range(0, 1))));
            kind = $urandom_range(0, 5);
            tx_q.push_back("*");
            case (kind)
                0, 1: begin
                    tx_q.push_back($urandom_range(0, 1) ? "W" : "w");
                    tx_q.push_back(byte'("0" + $urandom_range(0, NUM_REGS)));
                    for (int k = 0; k < ARG_CH; k++) tx_q.push_back(hexs[$urandom_range(0, 21)]);
                end
                2: begin
                    tx_q.push_back($urandom_range(0, 1) ? "R" : "r");
                    tx_q.push_back(byte'("0" + $urandom_range(0, NUM_REGS)));
                end
                3: tx_q.push_back($urandom_range(0, 1) ? "C" : "c");
                4: tx_q.push_back("Z");
                default: begin
                    tx_q.push_back("W");
                    tx_q.push_back("1");
                    for (int k = 0; k < 3; k++) tx_q.push_back(hexs[$urandom_range(0, 21)]);
                    tx_q.push_back("g");
                end
            endcase
            for (int k = 0; k < tx_q.size(); k++) begin
                send_ch(tx_q[k], 1'b0);
                if (k == 0 && kind == 2 && $urandom_range(0, 1) == 1) send_ch("Q", 1'b1);
            end
            wait_idle();
            check("bus_random", bus.reg_bus, model_bus());
        end

        send_str("*W0123");
        #3 rst_clk_rx_n = 1'b0;
        #1 check_reset_outputs("async_rst");
        for (int i = 0; i < NUM_REGS; i++) m_regs[i] = '0;
        m_active = 1'b0;
        m_busy   = 1'b0;
        repeat (2) @(negedge clk_rx);
        rst_clk_rx_n = 1'b1;
        repeat (2) @(negedge clk_rx);
        send_str("*R0");
        wait_idle();

        repeat (5) @(negedge clk_rx);
        check("echo_q_drained", echo_q.size(), 0);
        check("wr_q_drained", wr_q.size(), 0);
        check("resp_q_drained", resp_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not complete, checks=%0d failures=%0d", n_checks, n_fail);
        $fatal(1, "watchdog expired");
    end
endmodule

// File: doc/cmd_parse_regs.md
Name: cmd_parse_regs

Overview:
Parametrised successor to the single-purpose UART command parser. It decodes ASCII commands from the Bluetooth UART receive path into a bank of NUM_REGS hex-loaded registers, one per control channel (speed, steering, mode, ...). It supports write, read-back and clear, and adds an inter-character timeout and mid-command resync. It sits between the UART receiver and the response generator / character FIFO, and drives the car control logic through reg_bus.

Parameters:
NUM_REGS, 4, number of registers/channels; legal range 1..16.
ARG_CH, 8, hex digits per argument; register width DW = 4*ARG_CH.
TO_CYC, 1000000, clk_rx cycles without a new character before a partial command is aborted; TO_CYC >= 2.

Ports:
clk_rx  in  1  clock
rst_clk_rx_n  in  1  reset, asynchronous, active-low
rx_data  in  8  received character
rx_data_rdy  in  1  character valid; level, held for several cycles
char_fifo_full  in  1  echo FIFO full
send_char_val  out  1  echo strobe, 1 cycle
send_char  out  8  echoed character
send_resp_val  out  1  response request, held until done
send_resp_type  out  2  00 OK, 01 ERR, 10 DATA
send_resp_data  out  DW  read-back value, valid with type DATA
send_resp_done  in  1  response generator finished
reg_bus  out  NUM_REGS*DW  register bank; reg i at [i*DW +: DW]
reg_wr_stb  out  1  1-cycle pulse on each register update
reg_wr_idx  out  4  index written; 0 after Clear

Behaviour:
- Reset (async assert, sync release): all outputs 0; state IDLE; send_resp_type = ERR (01); timeout counter 0.
- new_char = rx_data_rdy & ~rx_data_rdy_d1 & ~char_fifo_full. Characters arriving while the FIFO is full are dropped completely: no echo, no parse.
- Echo: send_char_val = 1 and send_char = rx_data in the cycle after new_char. This applies in every state, including SEND_RESP.
- Character matching uses rx_data[6:0]. Command letters are case-insensitive. Hex digits accept 0-9, A-F, a-f.
- Grammar: '*' cmd [idx] [arg]:
  - W idx d(ARG_CH-1)..d0 → write.
  - R idx → read.
  - C → clear all registers.
  - idx is one hex digit.
- States:
  - IDLE: on '*' → CMD_WAIT. Every other character is ignored.
  - CMD_WAIT:
    - W or R → GET_IDX.
    - C → zero every register, pulse reg_wr_stb, reg_wr_idx = 0, respond OK.
    - '*' → stay in CMD_WAIT.
    - Anything else → respond ERR.
  - GET_IDX:
    - Non-hex, or value >= NUM_REGS → ERR.
    - Valid index with R → respond DATA, send_resp_data = reg[idx].
    - Valid index with W → latch idx, load digit counter with ARG_CH-1, clear shift register → GET_ARG.
  - GET_ARG:
    - Each hex digit shifts in at the LSB; the MS digit arrives first.
    - On the final digit: reg[idx] = full DW value, reg_wr_stb pulses, reg_wr_idx = idx, respond OK.
    - Non-hex → ERR; the target register is left unchanged.
  - SEND_RESP: holds send_resp_val/type/data. When send_resp_done is sampled high, send_resp_val drops next cycle → IDLE. Parsing is suspended here.
- Resync: '*' received in GET_IDX or GET_ARG discards the partial command, sends no response, → CMD_WAIT.
- Timeout: the counter resets on every new_char and counts in CMD_WAIT, GET_IDX and GET_ARG. On reaching TO_CYC-1: respond ERR, discard the partial command. It is held at 0 in IDLE and SEND_RESP.
- Latency: response, register update and reg_wr_stb all appear in the cycle after the new_char that completes the command. An ERR is raised in the cycle after the offending character.
- A new_char and a timeout in the same cycle: the character wins.
- Registers change only on a completed W, a C, or reset. Reset mid-command aborts immediately with no response.

Test Plan:
- NUM_REGS=4, ARG_CH=8. Send "*W212345678" → reg_bus[95:64] = 32'h12345678; reg_wr_stb pulses once with idx 2; resp OK; 11 echo strobes. Then send "*r2" → resp DATA with send_resp_data = 32'h12345678.
- "*W5..." with NUM_REGS=4 → ERR after the '5'; reg_bus unchanged. "*W01234G" → ERR on 'G'; reg 0 unchanged.
- TO_CYC=20: send "*W0AB" then stay idle → ERR exactly 20 cycles after the 'B'; a following "*R0" returns the old value.
- "*W0FF*W1DEADBEEF" → reg1 = DEADBEEF; reg0 unchanged; exactly one OK.
- After writes, "*c" → reg_bus = 0, reg_wr_stb pulse, OK. Hold send_resp_done low for 50 cycles with characters arriving → chars echoed, no parse, send_resp_val held high.
- Assert rst_clk_rx_n low asynchronously mid-GET_ARG → all outputs 0 with no clock edge needed; the next "*R0" after reset returns DATA 0.
